// File: rtl/rsp_fifo_if.sv
// Response stream bundle between the response arbiter, rsp_fifo and the host.
// The slave modport is the FIFO's view; master is the environment driving it.
interface rsp_fifo_if #(
    parameter int RSP_WIDTH = 32
);
    logic                 rsp_write_en;
    logic [RSP_WIDTH-1:0] rsp_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [RSP_WIDTH-1:0] rsp_out;

    modport master (
        output rsp_write_en,
        output rsp_data,
        output rsp_ready,
        input  rsp_valid,
        input  rsp_out
    );

    modport slave (
        input  rsp_write_en,
        input  rsp_data,
        input  rsp_ready,
        output rsp_valid,
        output rsp_out
    );
endinterface

// File: rtl/rsp_fifo.sv
// First-word-fall-through response buffer that absorbs backpressure-free write strobes
// and counts writes lost while full instead of stalling the arbiter.
module rsp_fifo #(
    parameter int RSP_WIDTH    = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 14,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    rsp_fifo_if.slave        bus,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    input  logic             overflow_clr
);

    logic [RSP_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        full = (count_q == CNT_W'(DEPTH));
        pop  = (count_q != '0) && bus.rsp_ready;
        // A full buffer still accepts a write when the head leaves in the same cycle.
        push = bus.rsp_write_en && (!full || pop);
        drop = bus.rsp_write_en && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; validity comes entirely from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.rsp_data;
        end
    end

    always_comb begin
        bus.rsp_valid = (count_q != '0);
        bus.rsp_out   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        count         = count_q;
        almost_full   = (count_q >= CNT_W'(AFULL_THRESH));
        overflow      = overflow_q;
        drop_cnt      = drop_cnt_q;
    end

endmodule

// File: tb/tb_rsp_fifo.sv
// Directed bench for rsp_fifo: a queue-based reference model checked every cycle,
// plus literal expectations taken from the documented scenarios.
module tb_rsp_fifo;

    localparam int RSP_WIDTH    = 32;
    localparam int DEPTH        = 16;
    localparam int AFULL_THRESH = 14;
    localparam int CNT_W        = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] count;
    logic             almost_full;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             overflow_clr;

    int n_checks;
    int n_fail;

    rsp_fifo_if #(.RSP_WIDTH(RSP_WIDTH)) bus ();

    rsp_fifo #(
        .RSP_WIDTH   (RSP_WIDTH),
        .DEPTH       (DEPTH),
        .AFULL_THRESH(AFULL_THRESH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the buffer is just a queue of accepted words.
    logic [RSP_WIDTH-1:0] model_q[$];
    logic                 m_overflow;
    int                   m_drops;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            m_overflow = 1'b0;
            m_drops    = 0;
        end else begin
            bit did_pop;
            bit did_drop;
            did_pop  = (model_q.size() != 0) && bus.rsp_ready;
            did_drop = 1'b0;
            if (did_pop) void'(model_q.pop_front());
            if (bus.rsp_write_en) begin
                if (model_q.size() < DEPTH) model_q.push_back(bus.rsp_data);
                else did_drop = 1'b1;
            end
            if (did_drop) begin
                m_overflow = 1'b1;
                m_drops    = overflow_clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end else if (overflow_clr) begin
                m_overflow = 1'b0;
                m_drops    = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] exp_out;
        exp_out = (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0;
        checkOutput("cyc_valid", 32'(bus.rsp_valid), 32'(model_q.size() != 0));
        checkOutput("cyc_out", 32'(bus.rsp_out), exp_out);
        checkOutput("cyc_count", 32'(count), 32'(model_q.size()));
        checkOutput("cyc_afull", 32'(almost_full), 32'(model_q.size() >= AFULL_THRESH));
        checkOutput("cyc_overflow", 32'(overflow), 32'(m_overflow));
        checkOutput("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    end

    // Drive one cycle of inputs, then return just after the edge that consumed them.
    task automatic applyStimulus(input logic we, input logic [31:0] data,
                                 input logic rdy, input logic clr);
        bus.rsp_write_en = we;
        bus.rsp_data     = data;
        bus.rsp_ready    = rdy;
        overflow_clr     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic resetCycle();
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus.rsp_write_en = 1'b0;
        bus.rsp_data     = '0;
        bus.rsp_ready    = 1'b0;
        overflow_clr     = 1'b0;

        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("reset_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_out", bus.rsp_out, 32'd0);
        rst_n = 1'b1;

        $display("[TB] in-order FWFT read");
        applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0);
        checkOutput("s1_count1", 32'(count), 32'd1);
        checkOutput("s1_head", bus.rsp_out, 32'hA1);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0);
        checkOutput("s1_count2", 32'(count), 32'd2);
        applyStimulus(1'b1, 32'hA3, 1'b0, 1'b0);
        checkOutput("s1_count3", 32'(count), 32'd3);
        checkOutput("s1_head_held", bus.rsp_out, 32'hA1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("s1_pop1", bus.rsp_out, 32'hA2);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("s1_pop2", bus.rsp_out, 32'hA3);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("s1_empty_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("s1_empty_out", bus.rsp_out, 32'd0);

        $display("[TB] overflow by one");
        for (int i = 0; i <= 16; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
        checkOutput("s2_count", 32'(count), 32'd16);
        checkOutput("s2_afull", 32'(almost_full), 32'd1);
        checkOutput("s2_overflow", 32'(overflow), 32'd1);
        checkOutput("s2_drop_cnt", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("s2_drain", bus.rsp_out, 32'(i));
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        end
        checkOutput("s2_drained", 32'(bus.rsp_valid), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("s2_clr", 32'(overflow), 32'd0);

        $display("[TB] write while full with pop");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
        checkOutput("s3_count", 32'(count), 32'd16);
        checkOutput("s3_no_drop", 32'(overflow), 32'd0);
        checkOutput("s3_head", bus.rsp_out, 32'h21);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("s3_last_count", 32'(count), 32'd1);
        checkOutput("s3_last_word", bus.rsp_out, 32'h55);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

        $display("[TB] streaming through pointer wrap");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
            checkOutput("s4_stream", bus.rsp_out, 32'h100 + 32'(i));
            checkOutput("s4_count", 32'(count), 32'd1);
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

        $display("[TB] drop counter saturation and clear");
        for (int i = 0; i < 16 + 300; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        checkOutput("s5_sat", 32'(drop_cnt), 32'd255);
        checkOutput("s5_count", 32'(count), 32'd16);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("s5_clr_ovf", 32'(overflow), 32'd0);
        checkOutput("s5_clr_cnt", 32'(drop_cnt), 32'd0);
        applyStimulus(1'b1, 32'h999, 1'b0, 1'b1);
        checkOutput("s5_set_wins_ovf", 32'(overflow), 32'd1);
        checkOutput("s5_set_wins_cnt", 32'(drop_cnt), 32'd1);
        checkOutput("s5_head", bus.rsp_out, 32'h300);

        $display("[TB] asynchronous reset mid-operation");
        resetCycle();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
        bus.rsp_write_en = 1'b0;
        checkOutput("s6_pre_count", 32'(count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s6_async_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("s6_async_count", 32'(count), 32'd0);
        checkOutput("s6_async_out", bus.rsp_out, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h7, 1'b0, 1'b0);
        checkOutput("s6_first", bus.rsp_out, 32'h7);
        checkOutput("s6_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsp_fifo.md
# rsp_fifo

Response buffer directly downstream of the response arbiter. It absorbs the arbiter's single-cycle write strobes, which carry no backpressure, and presents them to the host interface as a first-word-fall-through valid/ready stream. Responses that arrive while the buffer is full are counted and flagged rather than stalled. This lets the host diagnose lost allocate/free responses.

## Interface
- RSP_WIDTH, 32, width of one response word
- DEPTH, 16, number of entries; power of two, minimum 4
- AFULL_THRESH, 14, `almost_full` asserts when `count` >= this value; range 1..DEPTH
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rsp_write_en  input  1  write strobe from the arbiter; one word per asserted cycle
- rsp_data  input  RSP_WIDTH  word written when `rsp_write_en`=1
- rsp_valid  output  1  head word available
- rsp_ready  input  1  consumer accepts the head word when `rsp_valid` && `rsp_ready`
- rsp_out  output  RSP_WIDTH  head word; 0 when `rsp_valid`=0
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- almost_full  output  1  `count` >= AFULL_THRESH
- overflow  output  1  sticky; set by any dropped write
- drop_cnt  output  8  number of dropped writes, saturates at 255
- overflow_clr  input  1  single-cycle pulse; clears `overflow` and `drop_cnt`

## Operation
- Storage is a DEPTH-entry register array with a write pointer `wr_ptr` and a read pointer `rd_ptr`, each $clog2(DEPTH) bits wide. Both wrap naturally from DEPTH-1 to 0. The array itself is not reset.
- Occupancy is tracked by the registered `count`. The block is empty when `count`==0 and full when `count`==DEPTH.
- pop = `rsp_valid` && `rsp_ready`. A pop advances `rd_ptr`. `rsp_ready` has no effect while the buffer is empty.
- push = `rsp_write_en` && (!full || pop). A push writes `mem[wr_ptr]` and advances `wr_ptr`.
  - Write while full with a simultaneous pop: the write is accepted, because the popped slot is reused in the same cycle. `count` stays at DEPTH.
  - Write while full without a pop: this is a drop. The word is discarded, pointers and `count` are unchanged, `overflow` is set to 1, and `drop_cnt` increments, holding at 255 once saturated.
- Count update per cycle: push only gives +1, pop only gives -1, push and pop together give no change.
- Simultaneous push and pop on an empty buffer cannot occur, because pop requires `rsp_valid`. The push is accepted and `count` becomes 1.
- FWFT behaviour: `rsp_valid` = (`count` != 0), and `rsp_out` = `mem[rd_ptr]` when valid, 0 otherwise. Both are combinational from registered state; neither depends combinationally on any input.
- `overflow_clr` takes effect on the next edge: `overflow` is cleared to 0 and `drop_cnt` to 0.
  - If a drop happens in the same cycle as `overflow_clr`, set wins: `overflow`=1 and `drop_cnt`=1.
- The block runs as a single implicit state machine over `count`: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH). Transitions follow the count update rule above.

## Timing
- Reset, asynchronous: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `overflow`=0, `drop_cnt`=0. Consequently `rsp_valid`=0, `rsp_out`=0 and `almost_full`=0 immediately, with no clock edge required.
- Reset asserted mid-operation discards all stored words. No partial pop is visible after reset.
- Write-to-valid latency: a word written at edge N is presented on `rsp_valid`/`rsp_out` from edge N onward, i.e. the first cycle after the write cycle. There is no combinational bypass from input to output.
- Pop latency: the next word, or `rsp_valid`=0 if none remains, appears in the cycle after the accepting edge.
- The block must accept a write every cycle indefinitely while not full. This covers the arbiter's back-to-back two-word burst.
- `almost_full` and `count` update on the same edge as the push or pop that changes them.
- Sustained throughput is 1 word/cycle in and 1 word/cycle out concurrently.

## Test plan
- Reset, then write 0xA1, 0xA2, 0xA3 on consecutive cycles with `rsp_ready`=0 -> `count` reads 1,2,3; `rsp_out`=0xA1 from the cycle after the first write. Then hold `rsp_ready`=1 -> 0xA1, 0xA2, 0xA3 are popped in order and `rsp_valid` drops after the third.
- Write 17 words 0x00..0x10 into DEPTH=16 with `rsp_ready`=0 -> `count`=16, `overflow`=1, `drop_cnt`=1. Draining returns 0x00..0x0F; 0x10 is never output.
- Fill to 16, then write 0x55 with `rsp_ready`=1 in the same cycle -> no drop, `count` stays 16, and 0x55 is the last word drained.
- Run continuous write+pop for 40 cycles with incrementing data -> the output sequence equals the input sequence, delayed 1 cycle. This exercises pointer wrap-around.
- Force 300 drops -> `drop_cnt`=255. Pulse `overflow_clr` alone -> `overflow`=0 and `drop_cnt`=0. Pulse it again during a drop -> `overflow`=1 and `drop_cnt`=1.
- Assert `rst_n`=0 with 5 words stored -> `rsp_valid`=0, `count`=0 and `rsp_out`=0 without waiting for a clock edge. Release reset and write 0x7 -> 0x7 is output first.
